// File: rtl/axi_write_arbiter.sv
// Round-robin AW arbiter with an in-order W steering FIFO for one shared AXI4 write port.
// Payload muxes are external; this block drives the handshakes and the select indices.
module axi_write_arbiter #(
  parameter int unsigned NUM_INP  = 4,
  parameter int unsigned MAX_TXNS = 4,
  parameter int unsigned SEL_W    = $clog2(NUM_INP),
  parameter int unsigned CNT_W    = $clog2(MAX_TXNS + 1)
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [NUM_INP-1:0] inp_aw_valid_i,
  output logic [NUM_INP-1:0] inp_aw_ready_o,
  input  logic [NUM_INP-1:0] inp_w_valid_i,
  output logic [NUM_INP-1:0] inp_w_ready_o,
  output logic               oup_aw_valid_o,
  input  logic               oup_aw_ready_i,
  output logic [SEL_W-1:0]   aw_sel_o,
  output logic               oup_w_valid_o,
  input  logic               oup_w_ready_i,
  input  logic               oup_w_last_i,
  output logic [SEL_W-1:0]   w_sel_o,
  output logic [CNT_W-1:0]   outstanding_o
);

  localparam int unsigned PTR_W = (MAX_TXNS > 1) ? $clog2(MAX_TXNS) : 1;

  typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_LOCKED = 1'b1} aw_state_e;

  aw_state_e        state_r, state_s;
  logic [SEL_W-1:0] rr_r, lock_r, cand_s, head_s;
  logic             found_s, any_req_s, full_s, empty_s;
  logic             aw_hs_s, pop_s;
  logic [SEL_W-1:0] fifo_r [MAX_TXNS];
  logic [PTR_W-1:0] wr_ptr_r, rd_ptr_r;
  logic [CNT_W-1:0] count_r;

  function automatic logic [SEL_W-1:0] wrap_inc(input logic [SEL_W-1:0] base,
                                                input int unsigned step);
    int unsigned sum;
    sum = 32'(base) + step;
    if (sum >= NUM_INP) sum = sum - NUM_INP;
    else                sum = sum;
    return sum[SEL_W-1:0];
  endfunction

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] ptr);
    if (ptr == PTR_W'(MAX_TXNS - 1)) return {PTR_W{1'b0}};
    else                             return ptr + PTR_W'(1);
  endfunction

  assign any_req_s     = |inp_aw_valid_i;
  assign empty_s       = (count_r == {CNT_W{1'b0}});
  assign full_s        = (count_r == CNT_W'(MAX_TXNS));
  assign head_s        = fifo_r[rd_ptr_r];
  assign aw_hs_s       = oup_aw_valid_o & oup_aw_ready_i;
  assign pop_s         = oup_w_valid_o & oup_w_ready_i & oup_w_last_i;
  assign outstanding_o = count_r;

  // Round-robin candidate: first requester at or after the priority pointer.
  always_comb begin
    cand_s  = rr_r;
    found_s = 1'b0;
    for (int unsigned k = 0; k < NUM_INP; k++) begin
      if (!found_s && inp_aw_valid_i[wrap_inc(rr_r, k)]) begin
        cand_s  = wrap_inc(rr_r, k);
        found_s = 1'b1;
      end else begin
        found_s = found_s;
      end
    end
  end

  // AW state register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_r <= ST_IDLE;
    else       state_r <= state_s;
  end

  // AW next state: an unacknowledged offer locks the selection until handshake.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (any_req_s && !full_s && !oup_aw_ready_i) state_s = ST_LOCKED;
        else                                         state_s = ST_IDLE;
      end
      ST_LOCKED: begin
        if (oup_aw_ready_i) state_s = ST_IDLE;
        else                state_s = ST_LOCKED;
      end
      default: state_s = ST_IDLE;
    endcase
  end

  // AW outputs.
  always_comb begin
    oup_aw_valid_o = 1'b0;
    aw_sel_o       = {SEL_W{1'b0}};
    case (state_r)
      ST_IDLE: begin
        if (any_req_s && !full_s) begin
          oup_aw_valid_o = 1'b1;
          aw_sel_o       = cand_s;
        end else begin
          oup_aw_valid_o = 1'b0;
        end
      end
      ST_LOCKED: begin
        oup_aw_valid_o = 1'b1;
        aw_sel_o       = lock_r;
      end
      default: oup_aw_valid_o = 1'b0;
    endcase
  end

  // Per-master AW ready follows the shared handshake for the selected master only.
  always_comb begin
    inp_aw_ready_o = {NUM_INP{1'b0}};
    if (aw_hs_s) inp_aw_ready_o[aw_sel_o] = 1'b1;
    else         inp_aw_ready_o = {NUM_INP{1'b0}};
  end

  // Locked selection and round-robin pointer.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      lock_r <= {SEL_W{1'b0}};
      rr_r   <= {SEL_W{1'b0}};
    end else begin
      if (state_r == ST_IDLE && state_s == ST_LOCKED) lock_r <= cand_s;
      if (aw_hs_s) rr_r <= wrap_inc(aw_sel_o, 1);
    end
  end

  // Grant-order FIFO; a pop while full frees the slot only from the next cycle.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {CNT_W{1'b0}};
      for (int i = 0; i < MAX_TXNS; i++) fifo_r[i] <= {SEL_W{1'b0}};
    end else begin
      if (aw_hs_s) begin
        fifo_r[wr_ptr_r] <= aw_sel_o;
        wr_ptr_r         <= ptr_inc(wr_ptr_r);
      end
      if (pop_s) rd_ptr_r <= ptr_inc(rd_ptr_r);
      case ({aw_hs_s, pop_s})
        2'b10:   count_r <= count_r + CNT_W'(1);
        2'b01:   count_r <= count_r - CNT_W'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // W steering to the master at the FIFO head.
  always_comb begin
    w_sel_o       = {SEL_W{1'b0}};
    oup_w_valid_o = 1'b0;
    inp_w_ready_o = {NUM_INP{1'b0}};
    if (!empty_s) begin
      w_sel_o               = head_s;
      oup_w_valid_o         = inp_w_valid_i[head_s];
      inp_w_ready_o[head_s] = oup_w_ready_i;
    end else begin
      w_sel_o = {SEL_W{1'b0}};
    end
  end

endmodule

// File: tb/tb_axi_write_arbiter.sv
// Directed self-checking bench for axi_write_arbiter (NUM_INP=4, MAX_TXNS=4).
module tb_axi_write_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] inp_aw_valid, inp_aw_ready, inp_w_valid, inp_w_ready;
  logic       oup_aw_valid, oup_aw_ready, oup_w_valid, oup_w_ready, oup_w_last;
  logic [1:0] aw_sel, w_sel;
  logic [2:0] outstanding;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  axi_write_arbiter #(.NUM_INP(4), .MAX_TXNS(4)) dut (
    .clk_i(clk), .rst_i(rst),
    .inp_aw_valid_i(inp_aw_valid), .inp_aw_ready_o(inp_aw_ready),
    .inp_w_valid_i(inp_w_valid), .inp_w_ready_o(inp_w_ready),
    .oup_aw_valid_o(oup_aw_valid), .oup_aw_ready_i(oup_aw_ready), .aw_sel_o(aw_sel),
    .oup_w_valid_o(oup_w_valid), .oup_w_ready_i(oup_w_ready), .oup_w_last_i(oup_w_last),
    .w_sel_o(w_sel), .outstanding_o(outstanding)
  );

  // {aw_valid, aw_sel, inp_aw_ready} and {w_valid, w_sel, inp_w_ready, outstanding}
  wire [6:0] obs_aw = {oup_aw_valid, aw_sel, inp_aw_ready};
  wire [9:0] obs_w  = {oup_w_valid, w_sel, inp_w_ready, outstanding};

  // Stimulus vector: {aw_valid[3:0], aw_ready, w_valid[3:0], w_ready, w_last}
  task automatic drive(input logic [10:0] s);
    {inp_aw_valid, oup_aw_ready, inp_w_valid, oup_w_ready, oup_w_last} = s;
  endtask

  task automatic cyc;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst = 1'b1;
    drive(11'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    drive(11'd0);
    #2;
    checks++;
    if ({obs_aw, obs_w} !== 17'd0) begin
      errors++;
      $display("FAIL reset_async got %b expected %b", {obs_aw, obs_w}, 17'd0);
    end
    cyc;
    checks++;
    if ({obs_aw, obs_w} !== 17'd0) begin
      errors++;
      $display("FAIL reset_held got %b expected %b", {obs_aw, obs_w}, 17'd0);
    end
  endtask

  task automatic test_basic_grant;
    logic [10:0] st [6];
    logic [16:0] ex [6];
    st[0] = {4'b0101, 1'b1, 4'b0000, 1'b0, 1'b0}; ex[0] = {1'b1, 2'd0, 4'b0001, 1'b0, 2'd0, 4'b0000, 3'd0};
    st[1] = {4'b0100, 1'b1, 4'b0001, 1'b1, 1'b0}; ex[1] = {1'b1, 2'd2, 4'b0100, 1'b1, 2'd0, 4'b0001, 3'd1};
    st[2] = {4'b0000, 1'b1, 4'b0001, 1'b1, 1'b0}; ex[2] = {1'b0, 2'd0, 4'b0000, 1'b1, 2'd0, 4'b0001, 3'd2};
    st[3] = {4'b0000, 1'b1, 4'b0001, 1'b1, 1'b1}; ex[3] = {1'b0, 2'd0, 4'b0000, 1'b1, 2'd0, 4'b0001, 3'd2};
    st[4] = {4'b0000, 1'b1, 4'b0100, 1'b1, 1'b1}; ex[4] = {1'b0, 2'd0, 4'b0000, 1'b1, 2'd2, 4'b0100, 3'd1};
    st[5] = {4'b0000, 1'b1, 4'b0000, 1'b1, 1'b0}; ex[5] = {1'b0, 2'd0, 4'b0000, 1'b0, 2'd0, 4'b0000, 3'd0};
    do_reset;
    for (int i = 0; i < 6; i++) begin
      cyc;
      drive(st[i]);
      #1;
      checks++;
      if ({obs_aw, obs_w} !== ex[i]) begin
        errors++;
        $display("FAIL basic_grant[%0d] got %b expected %b", i, {obs_aw, obs_w}, ex[i]);
      end
    end
  endtask

  task automatic test_fairness;
    logic [1:0] g, h;
    logic [6:0] ea;
    logic [9:0] ew;
    do_reset;
    for (int k = 0; k < 8; k++) begin
      cyc;
      drive({4'b1111, 1'b1, 4'b1111, 1'b1, 1'b1});
      #1;
      g  = 2'(k);
      h  = g - 2'd1;
      ea = {1'b1, g, 4'b0001 << g};
      ew = (k == 0) ? 10'd0 : {1'b1, h, 4'b0001 << h, 3'd1};
      checks++;
      if ({obs_aw, obs_w} !== {ea, ew}) begin
        errors++;
        $display("FAIL fairness[%0d] got %b expected %b", k, {obs_aw, obs_w}, {ea, ew});
      end
    end
  endtask

  task automatic test_locked_hold;
    logic [10:0] st [6];
    logic [6:0]  ex [6];
    st[0] = {4'b0010, 1'b0, 6'd0}; ex[0] = {1'b1, 2'd1, 4'b0000};
    st[1] = {4'b0011, 1'b0, 6'd0}; ex[1] = {1'b1, 2'd1, 4'b0000};
    st[2] = {4'b0011, 1'b0, 6'd0}; ex[2] = {1'b1, 2'd1, 4'b0000};
    st[3] = {4'b0011, 1'b1, 6'd0}; ex[3] = {1'b1, 2'd1, 4'b0010};
    st[4] = {4'b0001, 1'b1, 6'd0}; ex[4] = {1'b1, 2'd0, 4'b0001};
    st[5] = {4'b0000, 1'b0, 6'd0}; ex[5] = {1'b0, 2'd0, 4'b0000};
    do_reset;
    for (int i = 0; i < 6; i++) begin
      cyc;
      drive(st[i]);
      #1;
      checks++;
      if (obs_aw !== ex[i]) begin
        errors++;
        $display("FAIL locked_hold[%0d] got %b expected %b", i, obs_aw, ex[i]);
      end
    end
  endtask

  task automatic test_full_fifo;
    logic [10:0] st [8];
    logic [16:0] ex [8];
    st[0] = {4'b1111, 1'b1, 6'd0}; ex[0] = {1'b1, 2'd0, 4'b0001, 1'b0, 2'd0, 4'b0000, 3'd0};
    st[1] = {4'b1111, 1'b1, 6'd0}; ex[1] = {1'b1, 2'd1, 4'b0010, 1'b0, 2'd0, 4'b0000, 3'd1};
    st[2] = {4'b1111, 1'b1, 6'd0}; ex[2] = {1'b1, 2'd2, 4'b0100, 1'b0, 2'd0, 4'b0000, 3'd2};
    st[3] = {4'b1111, 1'b1, 6'd0}; ex[3] = {1'b1, 2'd3, 4'b1000, 1'b0, 2'd0, 4'b0000, 3'd3};
    st[4] = {4'b1111, 1'b1, 6'd0}; ex[4] = {1'b0, 2'd0, 4'b0000, 1'b0, 2'd0, 4'b0000, 3'd4};
    st[5] = {4'b1111, 1'b1, 4'b0001, 1'b1, 1'b1}; ex[5] = {1'b0, 2'd0, 4'b0000, 1'b1, 2'd0, 4'b0001, 3'd4};
    st[6] = {4'b1111, 1'b1, 6'd0}; ex[6] = {1'b1, 2'd0, 4'b0001, 1'b0, 2'd1, 4'b0000, 3'd3};
    st[7] = {4'b0000, 1'b0, 6'd0}; ex[7] = {1'b0, 2'd0, 4'b0000, 1'b0, 2'd1, 4'b0000, 3'd4};
    do_reset;
    for (int i = 0; i < 8; i++) begin
      cyc;
      drive(st[i]);
      #1;
      checks++;
      if ({obs_aw, obs_w} !== ex[i]) begin
        errors++;
        $display("FAIL full_fifo[%0d] got %b expected %b", i, {obs_aw, obs_w}, ex[i]);
      end
    end
  endtask

  task automatic test_early_w;
    logic [10:0] st [4];
    logic [16:0] ex [4];
    st[0] = {4'b0000, 1'b0, 4'b1000, 1'b1, 1'b0}; ex[0] = {7'd0, 1'b0, 2'd0, 4'b0000, 3'd0};
    st[1] = {4'b1000, 1'b1, 4'b1000, 1'b1, 1'b0}; ex[1] = {1'b1, 2'd3, 4'b1000, 1'b0, 2'd0, 4'b0000, 3'd0};
    st[2] = {4'b0000, 1'b0, 4'b1000, 1'b1, 1'b1}; ex[2] = {7'd0, 1'b1, 2'd3, 4'b1000, 3'd1};
    st[3] = {4'b0000, 1'b0, 4'b0000, 1'b1, 1'b0}; ex[3] = {7'd0, 1'b0, 2'd0, 4'b0000, 3'd0};
    do_reset;
    for (int i = 0; i < 4; i++) begin
      cyc;
      drive(st[i]);
      #1;
      checks++;
      if ({obs_aw, obs_w} !== ex[i]) begin
        errors++;
        $display("FAIL early_w[%0d] got %b expected %b", i, {obs_aw, obs_w}, ex[i]);
      end
    end
  endtask

  task automatic test_reset_mid_burst;
    do_reset;
    cyc;
    drive({4'b0001, 1'b1, 6'd0});
    for (int b = 0; b < 2; b++) begin
      cyc;
      drive({4'b0000, 1'b0, 4'b0001, 1'b1, 1'b0});
      #1;
      checks++;
      if (obs_w !== {1'b1, 2'd0, 4'b0001, 3'd1}) begin
        errors++;
        $display("FAIL mid_burst_beat[%0d] got %b expected %b", b, obs_w, {1'b1, 2'd0, 4'b0001, 3'd1});
      end
    end
    rst = 1'b1;
    #1;
    checks++;
    if ({obs_aw, obs_w} !== 17'd0) begin
      errors++;
      $display("FAIL mid_burst_reset got %b expected %b", {obs_aw, obs_w}, 17'd0);
    end
    cyc;
    rst = 1'b0;
    #1;
    checks++;
    if (obs_w !== 10'd0) begin
      errors++;
      $display("FAIL mid_burst_after got %b expected %b", obs_w, 10'd0);
    end
  endtask

  initial begin
    test_reset;
    test_basic_grant;
    test_fairness;
    test_locked_hold;
    test_full_fifo;
    test_early_w;
    test_reset_mid_burst;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
